// File: rtl/memory_bus_master_pkg.sv
// Shared definitions for the external memory bus initiator: state
// encodings, bus widths, idle bus values and the timing constants the
// memory controller side uses as well.
package memory_bus_master_pkg;

  localparam int DataBusWidth    = 32;
  localparam int AddressBusWidth = 32;
  localparam int WaitCountWidth  = 8;

  localparam logic [DataBusWidth-1:0]    DataBusZ       = {DataBusWidth{1'bz}};
  localparam logic [AddressBusWidth-1:0] AddressBusZero = '0;

  localparam int TimeoutCyclesDefault = 15;

  // Responder access delays, kept identical to the memory controller defines
  localparam int RespDelayNonSeq = 6;
  localparam int RespDelaySeq    = 2;

  typedef enum logic [1:0] {
    StateIdle  = 2'd0,
    StateIssue = 2'd1,
    StateWait  = 2'd2,
    StateResp  = 2'd3
  } busState_t;

  // Sequential accesses only make sense for writes; reads always go out
  // as non-sequential so the responder performs a full access.
  function automatic logic issueSeq(input logic seq, input logic write);
    return seq & write;
  endfunction

endpackage

// File: rtl/memory_bus_master_bus_wait_timer.sv
// Bus wait timer: counts WAIT cycles of the outstanding transaction,
// clears when a new WAIT phase starts and saturates instead of wrapping.
// 'timeout' is high in the last WAIT cycle before the limit is reached,
// so the edge that ends that cycle is the one that hits TIMEOUT_CYCLES.
module memory_bus_master_bus_wait_timer
  import memory_bus_master_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TimeoutCyclesDefault
) (
  input  logic MCLK,
  input  logic nRESET,
  input  logic clear,
  input  logic enable,
  output logic timeout
);

  localparam logic [WaitCountWidth-1:0] CountMax    = {WaitCountWidth{1'b1}};
  localparam logic [WaitCountWidth-1:0] TimeoutLast = WaitCountWidth'(TIMEOUT_CYCLES - 1);

  logic [WaitCountWidth-1:0] waitCount;

  // Clearable, saturating WAIT cycle counter
  always_ff @(posedge MCLK or negedge nRESET) begin
    if (!nRESET) begin
      waitCount <= '0;
    end else if (clear) begin
      waitCount <= '0;
    end else if (enable && (waitCount != CountMax)) begin
      waitCount <= waitCount + 1'b1;
    end
  end

  assign timeout = (waitCount >= TimeoutLast);

endmodule

// File: rtl/memory_bus_master.sv
// Memory bus master: turns single-word core requests into one external
// bus transaction (ISSUE for one cycle, then WAIT on nWAIT) and returns
// read data, write completion or a timeout error as a one-cycle pulse.
module memory_bus_master
  import memory_bus_master_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TimeoutCyclesDefault
) (
  input  logic                       MCLK,
  input  logic                       nRESET,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic [AddressBusWidth-1:0] req_addr,
  input  logic [DataBusWidth-1:0]    req_wdata,
  input  logic                       req_write,
  input  logic                       req_seq,
  output logic                       rsp_valid,
  output logic [DataBusWidth-1:0]    rsp_rdata,
  output logic                       rsp_err,
  output logic [AddressBusWidth-1:0] AddressBus,
  inout  tri   [DataBusWidth-1:0]    DataBus,
  output logic                       nRW,
  output logic                       nBW,
  output logic                       nMREQ,
  output logic                       SEQ,
  input  logic                       nWAIT
);

  busState_t state;
  busState_t nextState;

  logic [AddressBusWidth-1:0] outAddr;
  logic [DataBusWidth-1:0]    outWdata;
  logic                       outWrite;
  logic                       outSeq;

  logic accept;
  logic driveData;
  logic timerClear;
  logic timerEnable;
  logic timeout;
  logic waitDone;
  logic waitExpired;

  memory_bus_master_bus_wait_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) waitTimer (
    .MCLK   (MCLK),
    .nRESET (nRESET),
    .clear  (timerClear),
    .enable (timerEnable),
    .timeout(timeout)
  );

  // State register; an asynchronous reset abandons any transaction in flight
  always_ff @(posedge MCLK or negedge nRESET) begin
    if (!nRESET) begin
      state <= StateIdle;
    end else begin
      state <= nextState;
    end
  end

  // Next-state and bus outputs; everything is idle unless ISSUE drives it
  always_comb begin
    nextState   = state;
    req_ready   = 1'b0;
    rsp_valid   = 1'b0;
    nMREQ       = 1'b1;
    nRW         = 1'b0;
    SEQ         = 1'b0;
    AddressBus  = AddressBusZero;
    driveData   = 1'b0;
    timerClear  = 1'b0;
    timerEnable = 1'b0;
    accept      = 1'b0;
    waitDone    = 1'b0;
    waitExpired = 1'b0;
    case (state)
      StateIdle: begin
        req_ready = nWAIT;
        accept    = req_valid & nWAIT;
        if (accept) begin
          nextState = StateIssue;
        end
      end
      StateIssue: begin
        nMREQ      = 1'b0;
        AddressBus = outAddr;
        nRW        = outWrite;
        SEQ        = outSeq;
        driveData  = outWrite;
        timerClear = 1'b1;
        nextState  = StateWait;
      end
      StateWait: begin
        timerEnable = 1'b1;
        if (nWAIT) begin
          waitDone  = 1'b1;
          nextState = StateResp;
        end else if (timeout) begin
          waitExpired = 1'b1;
          nextState   = StateResp;
        end
      end
      StateResp: begin
        rsp_valid = 1'b1;
        nextState = StateIdle;
      end
      default: begin
        nextState = StateIdle;
      end
    endcase
  end

  // Outstanding request registers and the response data/error latches
  always_ff @(posedge MCLK or negedge nRESET) begin
    if (!nRESET) begin
      outAddr   <= AddressBusZero;
      outWdata  <= '0;
      outWrite  <= 1'b0;
      outSeq    <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      if (accept) begin
        outAddr  <= req_addr;
        outWdata <= req_wdata;
        outWrite <= req_write;
        outSeq   <= issueSeq(req_seq, req_write);
      end
      if (waitDone) begin
        if (!outWrite) begin
          rsp_rdata <= DataBus;
        end
        rsp_err <= 1'b0;
      end else if (waitExpired) begin
        rsp_err <= 1'b1;
      end
    end
  end

  assign DataBus = driveData ? outWdata : DataBusZ;
  assign nBW     = 1'b1;

endmodule

// File: tb/tb_memory_bus_master.sv
// Bench for memory_bus_master: a behavioural memory responder on the bus,
// a scoreboard of expected responses and bus issues, and directed requests.
module tb_memory_bus_master;

  localparam logic [31:0] Filler = 32'h5A5AA5A5;

  typedef struct {
    logic [31:0] rdata;
    logic        checkData;
    logic        err;
    int          dueCycle;
    int          gap;
  } rspExp_t;

  typedef struct {
    logic [31:0] addr;
    logic        write;
    logic [31:0] wdata;
    logic        seq;
  } busExp_t;

  logic        MCLK;
  logic        nRESET;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        req_write;
  logic        req_seq;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [31:0] AddressBus;
  wire  [31:0] DataBus;
  logic        nRW;
  logic        nBW;
  logic        nMREQ;
  logic        SEQ;
  logic        nWAIT;

  logic [2:0]  remaining;
  logic        drvRead;
  logic        stuck;
  logic        stub;
  logic [31:0] rdData;
  logic [31:0] mem [0:63];

  int checks   = 0;
  int failures = 0;
  int cycle    = 0;

  rspExp_t rspQ[$];
  busExp_t busQ[$];

  memory_bus_master #(.TIMEOUT_CYCLES(15)) dut (
    .MCLK      (MCLK),
    .nRESET    (nRESET),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_write (req_write),
    .req_seq   (req_seq),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .AddressBus(AddressBus),
    .DataBus   (DataBus),
    .nRW       (nRW),
    .nBW       (nBW),
    .nMREQ     (nMREQ),
    .SEQ       (SEQ),
    .nWAIT     (nWAIT)
  );

  initial MCLK = 1'b0;
  always #5 MCLK = ~MCLK;

  // Cycle index: number of rising edges seen so far
  always @(posedge MCLK) cycle++;

  // Responder: latches at the edge ending ISSUE, then holds nWAIT low for
  // 5 cycles (non-sequential) or 2 cycles (sequential)
  always @(posedge MCLK or negedge nRESET) begin
    if (!nRESET) begin
      remaining <= 3'd0;
      drvRead   <= 1'b0;
      stuck     <= 1'b0;
    end else if (!nMREQ) begin
      remaining <= SEQ ? 3'd2 : 3'd5;
      drvRead   <= !nRW;
      stuck     <= stub;
      rdData    <= mem[AddressBus[7:2]];
      if (nRW) mem[AddressBus[7:2]] <= DataBus;
    end else if (remaining != 3'd0) begin
      remaining <= remaining - 3'd1;
    end
  end

  assign nWAIT   = (remaining == 3'd0) && !(stuck && stub);
  assign DataBus = (drvRead && nMREQ) ? ((remaining == 3'd0) ? rdData : Filler) : 32'bz;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, actual, expected, cycle);
    end
  endtask

  task automatic checkResetValues();
    checkOutput("rstReqReady",  {31'b0, req_ready}, 32'd1);
    checkOutput("rstRspValid",  {31'b0, rsp_valid}, 32'd0);
    checkOutput("rstRspRdata",  rsp_rdata,          32'd0);
    checkOutput("rstRspErr",    {31'b0, rsp_err},   32'd0);
    checkOutput("rstNMREQ",     {31'b0, nMREQ},     32'd1);
    checkOutput("rstNRW",       {31'b0, nRW},       32'd0);
    checkOutput("rstNBW",       {31'b0, nBW},       32'd1);
    checkOutput("rstSEQ",       {31'b0, SEQ},       32'd0);
    checkOutput("rstAddressBus", AddressBus,        32'd0);
  endtask

  // Must be entered just after a falling edge; returns at the falling edge
  // that follows the accepting rising edge
  task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] wdata,
                               input logic write, input logic seq,
                               input logic [31:0] expRdata, input logic expErr,
                               input int latency, input bit hold, input bit abort,
                               input int expWait, input int gap);
    int waitCnt;
    req_addr  = addr;
    req_wdata = wdata;
    req_write = write;
    req_seq   = seq;
    req_valid = 1'b1;
    waitCnt   = 0;
    while (req_ready !== 1'b1 && waitCnt < 100) begin
      @(negedge MCLK);
      waitCnt++;
    end
    if (req_ready !== 1'b1) begin
      checkOutput("acceptReady", {31'b0, req_ready}, 32'd1);
      req_valid = 1'b0;
      return;
    end
    if (expWait >= 0) checkOutput("readyWait", 32'(waitCnt), 32'(expWait));
    if (!abort) rspQ.push_back('{expRdata, !write, expErr, cycle + 1 + latency, gap});
    busQ.push_back('{addr, write, wdata, seq & write});
    @(posedge MCLK);
    @(negedge MCLK);
    if (!hold) req_valid = 1'b0;
  endtask

  task automatic waitDrain();
    int n = 0;
    while (rspQ.size() != 0 && n < 60) begin
      @(negedge MCLK);
      n++;
    end
    checkOutput("drainRsp", 32'(rspQ.size()), 32'd0);
    repeat (2) @(negedge MCLK);
  endtask

  // Response monitor: pops the scoreboard on every rsp_valid pulse
  initial begin
    int lastRsp = -1;
    rspExp_t e;
    forever begin
      @(negedge MCLK);
      if (nRESET === 1'b1 && rsp_valid !== 1'b0) begin
        if (rspQ.size() == 0) begin
          checkOutput("unexpectedRsp", {31'b0, rsp_valid}, 32'd0);
        end else begin
          e = rspQ.pop_front();
          checkOutput("rspCycle", 32'(cycle), 32'(e.dueCycle));
          checkOutput("rspErr", {31'b0, rsp_err}, {31'b0, e.err});
          if (e.checkData) checkOutput("rspRdata", rsp_rdata, e.rdata);
          if (e.gap > 0) checkOutput("rspGap", 32'(cycle - lastRsp), 32'(e.gap));
          lastRsp = cycle;
        end
      end
    end
  end

  // Bus monitor: checks every ISSUE cycle against the expected request and
  // that the bus is idle everywhere else
  initial begin
    bit prevIssue = 0;
    bit prevRead  = 0;
    busExp_t b;
    forever begin
      @(negedge MCLK);
      if (nRESET !== 1'b1) begin
        prevIssue = 0;
      end else if (nMREQ === 1'b0) begin
        if (prevIssue) checkOutput("nMREQWidth", {31'b0, nMREQ}, 32'd1);
        if (busQ.size() == 0) begin
          checkOutput("unexpectedIssue", {31'b0, nMREQ}, 32'd1);
          prevRead = 0;
        end else begin
          b = busQ.pop_front();
          checkOutput("issueAddr", AddressBus, b.addr);
          checkOutput("issueNRW", {31'b0, nRW}, {31'b0, b.write});
          checkOutput("issueSEQ", {31'b0, SEQ}, {31'b0, b.seq});
          checkOutput("issueNBW", {31'b0, nBW}, 32'd1);
          if (b.write) checkOutput("issueData", DataBus, b.wdata);
          prevRead = !b.write;
        end
        prevIssue = 1;
      end else begin
        checkOutput("idleBus", {AddressBus[28:0], nBW, SEQ, nRW}, 32'b100);
        if (prevIssue && prevRead) checkOutput("waitDataReleased", DataBus, Filler);
        prevIssue = 0;
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached, %0d failures so far", failures);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'(i + 1) * 32'h11111111;
    stub      = 1'b0;
    nRESET    = 1'b0;
    req_valid = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    req_write = 1'b0;
    req_seq   = 1'b0;
    repeat (2) @(negedge MCLK);
    checkResetValues();
    nRESET = 1'b1;
    @(negedge MCLK);

    $display("[TB] non-sequential write then read back");
    applyStimulus(32'h10, 32'hDEADBEEF, 1'b1, 1'b0, 32'h0, 1'b0, 7, 0, 0, 0, 0);
    waitDrain();
    applyStimulus(32'h10, 32'hFFFFFFFF, 1'b0, 1'b0, 32'hDEADBEEF, 1'b0, 7, 0, 0, 0, 0);
    waitDrain();

    $display("[TB] sequential write, sequential-hint read");
    applyStimulus(32'h20, 32'h12345678, 1'b1, 1'b1, 32'h0, 1'b0, 4, 0, 0, 0, 0);
    waitDrain();
    applyStimulus(32'h20, 32'hFFFFFFFF, 1'b0, 1'b1, 32'h12345678, 1'b0, 7, 0, 0, 0, 0);
    waitDrain();

    $display("[TB] back-to-back reads with req_valid held");
    applyStimulus(32'h00, 32'hFFFFFFFF, 1'b0, 1'b0, 32'h11111111, 1'b0, 7, 1, 0, 0, 0);
    applyStimulus(32'h04, 32'hFFFFFFFF, 1'b0, 1'b0, 32'h22222222, 1'b0, 7, 1, 0, 8, 9);
    applyStimulus(32'h08, 32'hFFFFFFFF, 1'b0, 1'b0, 32'h33333333, 1'b0, 7, 0, 0, 8, 9);
    waitDrain();

    $display("[TB] stuck responder timeout");
    stub = 1'b1;
    applyStimulus(32'h30, 32'hFFFFFFFF, 1'b0, 1'b0, 32'h33333333, 1'b1, 16, 1, 0, 0, 0);
    req_addr = 32'h34;
    waitDrain();
    for (int i = 0; i < 10; i++) begin
      checkOutput("noAcceptWhileBusy", {31'b0, req_ready}, 32'd0);
      @(negedge MCLK);
    end
    req_valid = 1'b0;
    stub      = 1'b0;
    repeat (2) @(negedge MCLK);

    $display("[TB] reset pulse during WAIT of a read");
    applyStimulus(32'h04, 32'hFFFFFFFF, 1'b0, 1'b0, 32'h0, 1'b0, 7, 0, 1, 0, 0);
    repeat (3) @(negedge MCLK);
    #2 nRESET = 1'b0;
    #1 checkResetValues();
    @(negedge MCLK);
    @(negedge MCLK);
    nRESET = 1'b1;
    repeat (10) @(negedge MCLK);
    applyStimulus(32'h10, 32'hFFFFFFFF, 1'b0, 1'b0, 32'hDEADBEEF, 1'b0, 7, 0, 0, 0, 0);
    waitDrain();

    checkOutput("memWord10", mem[4], 32'hDEADBEEF);
    checkOutput("memWord20", mem[8], 32'h12345678);
    checkOutput("busQueueEmpty", 32'(busQ.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
